// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the sequential ALU.
package alu_pkg;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NEG  = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_SHRA = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01010;
    localparam logic [4:0] OP_SHR  = 5'b01011;
    localparam logic [4:0] OP_ROL  = 5'b01110;
    localparam logic [4:0] OP_ROR  = 5'b01111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: iterative signed radix-2 Booth multiplier and, with SEQ_ALU_DIV_EN, non-restoring divider.
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               complete,
    output logic [2*WIDTH-1:0] result
);
    logic [CW-1:0]      cnt;
    logic               active, div_q, m_q1;
    logic [WIDTH:0]     m_hi, m_sum, m_hi_nx;
    logic [WIDTH-1:0]   m_lo, m_lo_nx, mcand;
    logic [2*WIDTH-1:0] prod;

    assign complete = active && cnt == CW'(WIDTH - 1);
    // Booth pair {Q0, Q-1}: 10 subtracts, 01 adds; hi carries one guard bit so M = -2^(W-1) cannot overflow
    assign m_sum   = (m_lo[0] && !m_q1) ? m_hi - {mcand[WIDTH-1], mcand}
                   : (!m_lo[0] && m_q1) ? m_hi + {mcand[WIDTH-1], mcand} : m_hi;
    assign m_hi_nx = {m_sum[WIDTH], m_sum[WIDTH:1]};
    assign m_lo_nx = {m_sum[0], m_lo[WIDTH-1:1]};
    assign prod    = {m_hi_nx[WIDTH-1:0], m_lo_nx};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt    <= '0;
            active <= 1'b0;
            div_q  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_q1   <= 1'b0;
            mcand  <= '0;
        end else if (load) begin
            cnt    <= '0;
            active <= 1'b1;
            div_q  <= is_div;
            m_hi   <= '0;
            m_lo   <= b;
            m_q1   <= 1'b0;
            mcand  <= a;
        end else if (active) begin
            cnt    <= cnt + 1'b1;
            active <= !complete;
            m_hi   <= m_hi_nx;
            m_lo   <= m_lo_nx;
            m_q1   <= m_lo[0];
        end
    end

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH+1:0] d_r, d_rs, d_rn;
    logic [WIDTH-1:0] d_q, d_qn, d_den, d_rem;
    logic             d_negq, d_negr;

    // Magnitudes are divided unsigned; signs are restored on the way out so the quotient truncates toward zero
    assign d_rs  = {d_r[WIDTH:0], d_q[WIDTH-1]};
    assign d_rn  = d_r[WIDTH+1] ? d_rs + {2'b00, d_den} : d_rs - {2'b00, d_den};
    assign d_qn  = {d_q[WIDTH-2:0], ~d_rn[WIDTH+1]};
    assign d_rem = d_rn[WIDTH+1] ? d_rn[WIDTH-1:0] + d_den : d_rn[WIDTH-1:0];
    assign result = div_q ? {d_negr ? -d_rem : d_rem, d_negq ? -d_qn : d_qn} : prod;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            d_r    <= '0;
            d_q    <= '0;
            d_den  <= '0;
            d_negq <= 1'b0;
            d_negr <= 1'b0;
        end else if (load) begin
            d_r    <= '0;
            d_q    <= a[WIDTH-1] ? -a : a;
            d_den  <= b[WIDTH-1] ? -b : b;
            d_negq <= a[WIDTH-1] ^ b[WIDTH-1];
            d_negr <= a[WIDTH-1];
        end else if (active && div_q) begin
            d_r    <= d_rn;
            d_q    <= d_qn;
        end
    end
`else
    assign result = div_q ? '0 : prod;
`endif
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU; single-cycle ops inline, MUL/DIV iterated in seq_muldiv_core.
// Divider is built only when SEQ_ALU_DIV_EN is defined; otherwise opcode 00100 is illegal.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] C_register,
    output logic               div_zero,
    output logic               illegal
);
    state_t                    state, state_nx;
    logic                      accept, is_div, is_muldiv, legal, dz, complete, big;
    logic [SHW-1:0]            sh, rot;
    logic [WIDTH-1:0]          lo;
    logic signed [WIDTH-1:0]   sra;
    logic [2*WIDTH-1:0]        single_res, core_res;

`ifdef SEQ_ALU_DIV_EN
    assign is_div = opcode == OP_DIV;
`else
    assign is_div = 1'b0;
`endif
    // Divide by zero is resolved in one cycle and never enters the core
    assign is_muldiv  = opcode == OP_MUL || (is_div && B != '0);
    assign accept     = state == IDLE && start;
    assign big        = B >= WIDTH'(WIDTH);
    assign sh         = B[SHW-1:0];
    assign rot        = SHW'(B % WIDTH'(WIDTH));
    assign sra        = $signed(A) >>> sh;
    assign single_res = dz ? {A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, lo};

    always_comb begin
        lo    = '0;
        legal = 1'b1;
        dz    = 1'b0;
        case (opcode)
            OP_ADD:  lo = A + B;
            OP_SUB:  lo = A - B;
            OP_MUL:  ;
`ifdef SEQ_ALU_DIV_EN
            OP_DIV:  dz = B == '0;
`endif
            OP_AND:  lo = A & B;
            OP_OR:   lo = A | B;
            OP_NEG:  lo = -B;
            OP_NOT:  lo = ~B;
            OP_SHRA: lo = big ? {WIDTH{A[WIDTH-1]}} : sra;
            OP_SHL:  lo = big ? '0 : A << sh;
            OP_SHR:  lo = big ? '0 : A >> sh;
            OP_ROL:  lo = (A << rot) | (A >> (WIDTH - int'(rot)));
            OP_ROR:  lo = (A >> rot) | (A << (WIDTH - int'(rot)));
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        done     = state == DONE;
        case (state)
            IDLE:    state_nx = start ? (is_muldiv ? RUN : DONE) : IDLE;
            RUN:     state_nx = complete ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            C_register <= '0;
            div_zero   <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                div_zero <= dz;
                illegal  <= !legal;
                if (!is_muldiv)
                    C_register <= single_res;
            end else if (state == RUN && complete) begin
                C_register <= core_res;
            end
        end
    end

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .clr      (clr),
        .load     (accept && is_muldiv),
        .is_div   (is_div),
        .a        (A),
        .b        (B),
        .complete (complete),
        .result   (core_res)
    );
endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised successor to the datapath ALU. It accepts one operation per start/done handshake and latches operand A (from the bus) and operand B (from Y) at start. Single-cycle ops finish in one cycle; MUL/DIV run in an iterative core, so the wide multiplier and divider arrays are not needed in the combinational path. The 2·WIDTH result feeds the Z (HI/LO) register pair exactly as the current ALU output does.

## Interface
- WIDTH, 32: operand width; must be even and ≥ 8.
- SHW, $clog2(WIDTH): width of the shift/rotate amount field.
- clk  in  1: rising-edge clock.
- clr  in  1: asynchronous reset, active-low.
- start  in  1: request; sampled only in IDLE.
- opcode  in  5: operation, with encoding unchanged from the datapath ALU (see Operation).
- A  in  WIDTH: operand A, treated as signed where the op needs a sign.
- B  in  WIDTH: operand B, or the shift/rotate amount.
- busy  out  1: high while an operation is in progress.
- done  out  1: one-cycle pulse when C_register is valid.
- C_register  out  2·WIDTH: result, with HI in [2W-1:W] and LO in [W-1:0]. Holds its value until the next done pulse.
- div_zero  out  1: DIV had B = 0. Valid with done and held until the next accepted start.
- illegal  out  1: opcode not in the table. Valid with done and held.

## Operation
- FSM states:
  - IDLE → RUN on start when opcode is MUL or DIV.
  - IDLE → DONE on start for any other opcode.
  - RUN → DONE when the iteration counter reaches WIDTH-1.
  - DONE → IDLE unconditionally.
- On the accepting edge, A, B and opcode are captured into internal registers. Input changes after that edge have no effect.
- Opcodes and results (HI = 0 unless stated):
  - 00001 ADD: LO = A+B mod 2^W.
  - 00010 SUB: LO = A−B mod 2^W.
  - 00011 MUL: signed radix-2 Booth, full 2W product in {HI,LO}.
  - 00100 DIV: signed non-restoring division, truncating toward zero. LO = quotient, HI = remainder; the remainder takes the sign of A.
  - 00101 AND, 00110 OR: bitwise.
  - 00111 NEG: LO = −B.
  - 01000 NOT: LO = ~B.
  - 01001 SHRA: arithmetic shift right.
  - 01010 SHL: logical shift left.
  - 01011 SHR: logical shift right (zero fill).
  - 01110 ROL / 01111 ROR: rotate by B mod WIDTH.
- Shift amounts: B is unsigned. If B ≥ WIDTH, SHL/SHR give 0 and SHRA gives all copies of A's sign bit.
- Edge cases:
  - DIV with B = 0: skips RUN, gives div_zero = 1, LO = all-ones, HI = A.
  - DIV of −2^(W-1) by −1: LO = −2^(W-1), HI = 0, no flag.
  - Unlisted opcode: C_register = 0 and illegal = 1.
- start while busy is ignored: no queuing, no error.
- clr asserted at any time, including mid-RUN: FSM → IDLE, the operation is aborted, and no done is produced.

## Timing
- Reset values: busy = 0, done = 0, C_register = 0, div_zero = 0, illegal = 0, FSM = IDLE, counter = 0.
- Accepting edge = edge t at which start = 1 in IDLE.
- Single-cycle ops (including DIV by zero and illegal opcodes): done = 1 and C_register valid in cycle t+1; busy is high in that same cycle only.
- MUL/DIV:
  - busy is high from t+1 through the done cycle.
  - done is high in cycle t+WIDTH+1, i.e. 33 cycles after the accepting edge for WIDTH = 32.
- Earliest next accept: the edge after the done cycle. Throughput is therefore one op per 2 cycles (single) or per WIDTH+2 cycles (MUL/DIV).
- done is never high for two consecutive cycles.

## Configuration
- SEQ_ALU_DIV_EN defined:
  - the divider datapath is built;
  - opcode 00100 behaves as above.
- SEQ_ALU_DIV_EN undefined:
  - no divider logic is built;
  - opcode 00100 is treated as illegal: single-cycle, C_register = 0, illegal = 1;
  - div_zero stays 0.
- MUL is always present.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_ROR);
  - the FSM state typedef (IDLE, RUN, DONE).
- One sub-module, seq_muldiv_core, handles the iteration:
  - ports: clk, clr, load, is_div, operand inputs, counter-complete output, {HI,LO} output;
  - it owns the Booth/non-restoring iteration and the counter;
  - seq_alu owns the FSM, the single-cycle ops and the output registers.

## Test plan
- ADD, A = 0x7FFFFFFF, B = 1 → C_register = 0x00000000_80000000, done at t+1, busy high one cycle.
- MUL, A = 0xFFFFFFFD (−3), B = 7 → C_register = 0xFFFFFFFF_FFFFFFEB, done at exactly t+33; a start pulse at t+10 is ignored.
- DIV, A = −17, B = 5 → C_register = 0xFFFFFFFE_FFFFFFFD. DIV, A = 9, B = 0 → C_register = 0x00000009_FFFFFFFF, div_zero = 1, done at t+1.
- ROR, A = 0x80000001, B = 33 → LO = 0xC0000000. SHRA, A = 0x80000000, B = 40 → LO = 0xFFFFFFFF. SHR, same operands → LO = 0.
- clr low at t+5 of a MUL → busy = 0, C_register = 0 immediately, and no done appears. A following ADD, A = 2, B = 3 → LO = 5 at t'+1.
- Opcode 11111 → C_register = 0, illegal = 1. With SEQ_ALU_DIV_EN undefined, opcode 00100 → illegal = 1 and div_zero = 0.
